// File: rtl/hcb_pkg.sv
// Shared definitions for the HCB packet sequencer: FSM state encoding,
// default parameter values and a small width helper.
package hcb_pkg;

   localparam int HCB_PACKETS_NUM    = 13;
   localparam int HCB_TDATA_WIDTH    = 32;
   localparam int HCB_RESULT_LATENCY = 1;

   // RECV: collecting beats, DRAIN: discarding until tlast,
   // WAIT: letting the chain settle, HOLD: presenting the clause result.
   typedef enum logic [1:0] {
      ST_RECV  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } hcb_state_e;

   // Bits needed to hold the values 0..n-1 (never less than one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hcb_onehot_dec.sv
// Beat-index to one-hot stage strobe decoder. The output is all zeros
// unless enable is set, so it can drive the stage strobes directly.
module hcb_onehot_dec
   import hcb_pkg::*;
#(
   parameter int PACKETS_NUM = HCB_PACKETS_NUM,
   parameter int IDX_W       = cnt_width(HCB_PACKETS_NUM)
) (
   input  logic [IDX_W-1:0]       index,
   input  logic                   enable,
   output logic [PACKETS_NUM-1:0] onehot
);

   // Raise exactly the bit selected by index when enabled.
   always_comb begin
      onehot = '0;
      for (int i = 0; i < PACKETS_NUM; i++) begin
         if (enable && (index == IDX_W'(i))) begin
            onehot[i] = 1'b1;
         end else begin
            onehot[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/hcb_packet_sequencer.sv
// Splits an AXI-Stream datapoint of PACKETS_NUM beats into one-hot stage
// strobes for the HCB chain, checks tlast framing, waits for the chain to
// settle and holds clause_valid until the consumer acknowledges it.
module hcb_packet_sequencer
   import hcb_pkg::*;
#(
   parameter int PACKETS_NUM            = HCB_PACKETS_NUM,
   parameter int C_S00_AXIS_TDATA_WIDTH = HCB_TDATA_WIDTH,
   parameter int RESULT_LATENCY         = HCB_RESULT_LATENCY
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
   input  logic                              s00_axis_tvalid,
   input  logic                              s00_axis_tlast,
   output logic                              s00_axis_tready,
   output logic [C_S00_AXIS_TDATA_WIDTH-1:0] x,
   output logic [PACKETS_NUM-1:0]            valid,
   output logic                              clause_valid,
   input  logic                              clause_ack,
   output logic                              framing_err,
   input  logic                              err_clr,
   output logic [31:0]                       dp_count
);

   localparam int IDX_W = cnt_width(PACKETS_NUM);
   localparam int LAT_W = cnt_width(RESULT_LATENCY + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKETS_NUM - 1);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RESULT_LATENCY);

   hcb_state_e                        state_r;
   hcb_state_e                        state_nxt_s;
   logic [IDX_W-1:0]                  idx_r;
   logic [IDX_W-1:0]                  idx_nxt_s;
   logic [LAT_W-1:0]                  lat_r;
   logic [LAT_W-1:0]                  lat_nxt_s;
   logic                              tready_r;
   logic                              tready_nxt_s;
   logic [C_S00_AXIS_TDATA_WIDTH-1:0] x_r;
   logic [PACKETS_NUM-1:0]            valid_r;
   logic                              clause_valid_r;
   logic                              clause_nxt_s;
   logic                              framing_err_r;
   logic [31:0]                       dp_count_r;
   logic                              handshake_s;
   logic                              good_beat_s;
   logic                              err_set_s;
   logic                              dp_inc_s;
   logic [PACKETS_NUM-1:0]            dec_onehot_s;

   assign handshake_s = s00_axis_tvalid & tready_r;

   // Next-state, beat classification and clause handshake decisions.
   always_comb begin
      state_nxt_s  = state_r;
      idx_nxt_s    = idx_r;
      lat_nxt_s    = lat_r;
      clause_nxt_s = clause_valid_r;
      good_beat_s  = 1'b0;
      err_set_s    = 1'b0;
      dp_inc_s     = 1'b0;
      case (state_r)
         ST_RECV: begin
            if (handshake_s) begin
               if (idx_r == LAST_IDX) begin
                  if (s00_axis_tlast) begin
                     good_beat_s = 1'b1;
                     idx_nxt_s   = '0;
                     lat_nxt_s   = LAT_INIT;
                     state_nxt_s = ST_WAIT;
                  end else begin
                     // Datapoint overran: throw away beats up to the next tlast.
                     err_set_s   = 1'b1;
                     idx_nxt_s   = '0;
                     state_nxt_s = ST_DRAIN;
                  end
               end else begin
                  if (s00_axis_tlast) begin
                     // Datapoint ended early: restart framing on the next beat.
                     err_set_s = 1'b1;
                     idx_nxt_s = '0;
                  end else begin
                     good_beat_s = 1'b1;
                     idx_nxt_s   = idx_r + IDX_W'(1);
                  end
               end
            end else begin
               state_nxt_s = ST_RECV;
            end
         end
         ST_DRAIN: begin
            if (handshake_s && s00_axis_tlast) begin
               idx_nxt_s   = '0;
               state_nxt_s = ST_RECV;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_WAIT: begin
            if (lat_r == '0) begin
               clause_nxt_s = 1'b1;
               dp_inc_s     = 1'b1;
               state_nxt_s  = ST_HOLD;
            end else begin
               lat_nxt_s = lat_r - LAT_W'(1);
            end
         end
         ST_HOLD: begin
            if (clause_ack) begin
               clause_nxt_s = 1'b0;
               idx_nxt_s    = '0;
               state_nxt_s  = ST_RECV;
            end else begin
               clause_nxt_s = 1'b1;
            end
         end
         default: begin
            clause_nxt_s = 1'b0;
            idx_nxt_s    = '0;
            state_nxt_s  = ST_RECV;
         end
      endcase
      tready_nxt_s = (state_nxt_s == ST_RECV) || (state_nxt_s == ST_DRAIN);
   end

   hcb_onehot_dec #(
      .PACKETS_NUM (PACKETS_NUM),
      .IDX_W       (IDX_W)
   ) u_dec (
      .index  (idx_r),
      .enable (good_beat_s),
      .onehot (dec_onehot_s)
   );

   // FSM state, beat index, settle counter and the registered ready flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_RECV;
         idx_r    <= '0;
         lat_r    <= '0;
         tready_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         idx_r    <= idx_nxt_s;
         lat_r    <= lat_nxt_s;
         tready_r <= tready_nxt_s;
      end
   end

   // Payload, stage strobes, clause flag, sticky error and datapoint counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r            <= '0;
         valid_r        <= '0;
         clause_valid_r <= 1'b0;
         framing_err_r  <= 1'b0;
         dp_count_r     <= 32'd0;
      end else begin
         if (good_beat_s) begin
            x_r <= s00_axis_tdata;
         end
         valid_r        <= dec_onehot_s;
         clause_valid_r <= clause_nxt_s;
         // A fresh error outranks a clear arriving on the same edge.
         if (err_set_s) begin
            framing_err_r <= 1'b1;
         end else if (err_clr) begin
            framing_err_r <= 1'b0;
         end
         if (dp_inc_s) begin
            dp_count_r <= dp_count_r + 32'd1;
         end
      end
   end

   assign s00_axis_tready = tready_r;
   assign x               = x_r;
   assign valid           = valid_r;
   assign clause_valid    = clause_valid_r;
   assign framing_err     = framing_err_r;
   assign dp_count        = dp_count_r;

endmodule
